// File: rtl/data_memory_lsu.sv
// data_memory_lsu
//   Load/store unit in front of a synchronous word-addressed RAM. It handles RV32
//   byte/half/word loads and stores, signed and unsigned, over a valid/ready
//   request and one-cycle response handshake. The load latency is configurable.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake (accept = valid & ready at posedge)
//   req_write             1 = store, 0 = load
//   req_funct3            RV32 funct3 size/sign code
//   req_address           byte address; bits above ADDR_BITS+1 are ignored
//   req_write_data        right-aligned store data
//   resp_valid            one-cycle response pulse
//   resp_read_data        extended load data (0 for stores, errors and idle)
//   resp_misaligned       address not aligned to the access size
//   resp_illegal          funct3 not legal for the direction
//   busy                  a request is outstanding
module data_memory_lsu #(
  parameter int ADDR_BITS    = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        resp_valid,
  output logic [31:0] resp_read_data,
  output logic        resp_misaligned,
  output logic        resp_illegal,
  output logic        busy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state;
  logic [2:0]         cnt;
  logic               data_ok_q;
  logic               mis_q;
  logic               ill_q;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [31:0]        rd_word;
  logic [31:0]        mem [0:DEPTH-1];

  logic               accept;
  logic               illegal;
  logic               misaligned;
  logic               good_load;
  logic               do_write;
  logic [ADDR_BITS-1:0] idx;
  logic [3:0]         strb;
  logic [31:0]        wdata;
  logic               unused_addr;

  // Byte-lane write strobes for a store of the given size at the given offset.
  function automatic logic [3:0] store_strobes(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] s;
    case (f3[1:0])
      2'd0:    s = 4'b0001 << off;
      2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Store data replicated into every lane so the strobes pick the right copy.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3[1:0])
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // Select the addressed byte/half from the sampled word and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req_ready   = (state != WAIT);
  assign busy        = (state != IDLE);
  assign resp_valid  = (state == RESP);
  assign accept      = req_valid & req_ready;
  assign idx         = req_address[ADDR_BITS+1:2];
  assign unused_addr = ^req_address[31:ADDR_BITS+2];

  // Illegal wins over misaligned; byte accesses are never misaligned.
  assign illegal    = req_write ? (req_funct3 > 3'd2)
                                : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
  assign misaligned = !illegal &&
                      ((req_funct3[1:0] == 2'd1 && req_address[0]) ||
                       (req_funct3[1:0] == 2'd2 && req_address[1:0] != 2'd0));
  assign good_load  = !req_write && !illegal && !misaligned;
  assign do_write   = accept && req_write && !illegal && !misaligned;
  assign strb       = store_strobes(req_funct3, req_address[1:0]);
  assign wdata      = store_lanes(req_funct3, req_write_data);

  // Control: request FSM and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      data_ok_q <= 1'b0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else if (accept) begin
      mis_q     <= misaligned;
      ill_q     <= illegal;
      data_ok_q <= good_load;
      if (good_load && READ_LATENCY > 1) begin
        state <= WAIT;
        cnt   <= 3'(READ_LATENCY - 1);
      end else begin
        state <= RESP;
      end
    end else if (state == WAIT) begin
      if (cnt == 3'd1) state <= RESP;
      else             cnt   <= cnt - 3'd1;
    end else begin
      state <= IDLE;
    end
  end

  // Datapath: RAM write on the accept edge, load word captured and held until the response.
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q  <= req_funct3;
      off_q <= req_address[1:0];
    end
    if (accept && good_load) rd_word <= mem[idx];
    for (int b = 0; b < 4; b++) begin
      if (do_write && strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  // Response outputs are forced to zero outside the response cycle.
  assign resp_read_data  = (resp_valid && data_ok_q) ? load_extend(rd_word, f3_q, off_q) : 32'd0;
  assign resp_misaligned = resp_valid & mis_q;
  assign resp_illegal    = resp_valid & ill_q;

endmodule
